countdown_timer: RTL and testbench

- Synchronous, loadable down-counter with a programmable prescaler, one-shot or auto-reload operation, and a terminal-count pulse.
- It is the decrementing complement of the existing ripple up-counter. The team uses it for timeouts, periodic ticks and delay generation.
- It is fully synchronous to one clock, so it can drive other synchronous logic with no glitch or ripple concerns.

---
 rtl/countdown_timer.sv | 142 ++++++++++++++
 tb/tb_countdown_timer.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/countdown_timer.sv
// -----------------------------------------------------------------------------
// countdown_timer
//
// Loadable, prescaled, synchronous down-counter with one-shot or auto-reload
// operation and a registered one-cycle terminal-count pulse.
//
// Ports:
//   clk          in   system clock, all state changes on the rising edge
//   reset        in   asynchronous active-low reset
//   load         in   copy load_value into the count and the reload register
//   load_value   in   [WIDTH]      count to load
//   prescale     in   [PRESCALE_W] one count tick every prescale+1 clocks
//   start        in   begin counting (IDLE) or restart from reload (DONE)
//   stop         in   pause counting; count and prescaler phase are held
//   auto_reload  in   1 = periodic, 0 = one-shot (sampled at the terminal tick)
//   q            out  [WIDTH] current count (registered)
//   busy         out  high while in RUN
//   done         out  high while in DONE
//   tc           out  one-cycle terminal-count pulse (registered)
//
// Control signals are level-sampled strobes: each cycle they are resolved in
// priority order load > stop > start. busy and done together fully decode
// the FSM state (neither = IDLE), so the state is observable at the ports.
// -----------------------------------------------------------------------------
module countdown_timer #(
    parameter int WIDTH      = 4,
    parameter int PRESCALE_W = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic [WIDTH-1:0]      load_value,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  auto_reload,
    output logic [WIDTH-1:0]      q,
    output logic                  busy,
    output logic                  done,
    output logic                  tc
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic [WIDTH-1:0]      q_q, q_d;
    logic [WIDTH-1:0]      reload_q, reload_d;
    logic [PRESCALE_W-1:0] pre_cnt_q, pre_cnt_d;
    logic                  tc_q, tc_d;

    // The prescaler only advances in RUN when neither load nor stop wins.
    logic run_ok;
    logic pre_wrap;
    logic tick;
    logic terminal;

    // >= rather than == so a prescale lowered below the current phase
    // produces a tick on the next cycle instead of wrapping the phase.
    assign run_ok   = (state_q == ST_RUN) && !load && !stop;
    assign pre_wrap = (pre_cnt_q >= prescale);
    assign tick     = run_ok && pre_wrap;
    // Count of 0 is treated like 1, so the counter never wraps to all-ones.
    assign terminal = tick && (q_q <= WIDTH'(1));

    // State register and datapath registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            q_q       <= '0;
            reload_q  <= '0;
            pre_cnt_q <= '0;
            tc_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            q_q       <= q_d;
            reload_q  <= reload_d;
            pre_cnt_q <= pre_cnt_d;
            tc_q      <= tc_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        if (load) begin
            state_d = ST_IDLE;
        end else if (stop) begin
            if (state_q == ST_RUN) begin
                state_d = ST_IDLE;
            end
        end else if (start && (state_q != ST_RUN)) begin
            state_d = ST_RUN;
        end else if (terminal && !auto_reload) begin
            state_d = ST_DONE;
        end
    end

    // Datapath next values.
    always_comb begin
        q_d       = q_q;
        reload_d  = reload_q;
        pre_cnt_d = pre_cnt_q;
        tc_d      = 1'b0;
        if (load) begin
            q_d       = load_value;
            reload_d  = load_value;
            pre_cnt_d = '0;
        end else if (!stop && start && (state_q == ST_DONE)) begin
            q_d       = reload_q;
            pre_cnt_d = '0;
        end else if (run_ok) begin
            if (pre_wrap) begin
                pre_cnt_d = '0;
            end else begin
                pre_cnt_d = pre_cnt_q + PRESCALE_W'(1);
            end
            if (tick) begin
                if (terminal) begin
                    tc_d = 1'b1;
                    // Reload on the terminal tick itself: no dead cycle
                    // between auto-reload periods.
                    q_d  = auto_reload ? reload_q : '0;
                end else begin
                    q_d = q_q - WIDTH'(1);
                end
            end
        end
    end

    // Outputs.
    always_comb begin
        busy = (state_q == ST_RUN);
        done = (state_q == ST_DONE);
        q    = q_q;
        tc   = tc_q;
    end

endmodule

// File: tb/tb_countdown_timer.sv
module tb_countdown_timer;

  localparam int WIDTH      = 4;
  localparam int PRESCALE_W = 8;

  // ---------------------------------------------------------------- clock/reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic                  load = 1'b0;
  logic [WIDTH-1:0]      load_value = '0;
  logic [PRESCALE_W-1:0] prescale = '0;
  logic                  start = 1'b0;
  logic                  stop = 1'b0;
  logic                  auto_reload = 1'b0;
  logic [WIDTH-1:0]      q;
  logic                  busy;
  logic                  done;
  logic                  tc;

  countdown_timer #(.WIDTH(WIDTH), .PRESCALE_W(PRESCALE_W)) dut (
    .clk         (clk),
    .reset       (rst_n),
    .load        (load),
    .load_value  (load_value),
    .prescale    (prescale),
    .start       (start),
    .stop        (stop),
    .auto_reload (auto_reload),
    .q           (q),
    .busy        (busy),
    .done        (done),
    .tc          (tc)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------- reference model
  // The timer viewed as: a mode, a count value, the value restored on restart
  // or reload, and how many clocks have accumulated toward the next count step.
  // A step happens on the clock where the accumulated clocks already reach
  // the prescale setting, i.e. one step per prescale+1 running clocks.
  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_DONE = 2;

  typedef struct {
    int mode;
    int cnt;
    int rel;
    int acc;
    bit tc;
  } mstate_t;

  mstate_t m = '{mode: M_IDLE, cnt: 0, rel: 0, acc: 0, tc: 1'b0};

  function automatic mstate_t model_next(mstate_t cur, bit ld, int lv, bit sp,
                                         bit st, bit ar, int ps);
    mstate_t n = cur;
    n.tc = 1'b0;
    if (ld) begin
      n.cnt = lv; n.rel = lv; n.acc = 0; n.mode = M_IDLE;
    end else if (sp) begin
      if (cur.mode == M_RUN) n.mode = M_IDLE;
    end else if (st && cur.mode == M_IDLE) begin
      n.mode = M_RUN;
    end else if (st && cur.mode == M_DONE) begin
      n.cnt = cur.rel; n.acc = 0; n.mode = M_RUN;
    end else if (cur.mode == M_RUN) begin
      if (cur.acc < ps) begin
        n.acc = cur.acc + 1;
      end else begin
        n.acc = 0;
        if (cur.cnt >= 2) begin
          n.cnt = cur.cnt - 1;
        end else begin
          n.tc = 1'b1;
          if (ar) n.cnt = cur.rel;
          else begin
            n.cnt = 0; n.mode = M_DONE;
          end
        end
      end
    end
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m <= '{mode: M_IDLE, cnt: 0, rel: 0, acc: 0, tc: 1'b0};
    else m <= model_next(m, load, int'(load_value), stop, start, auto_reload,
                         int'(prescale));
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    check("q_vs_model", int'(q), m.cnt);
    check("busy_vs_model", int'(busy), int'(m.mode == M_RUN));
    check("done_vs_model", int'(done), int'(m.mode == M_DONE));
    check("tc_vs_model", int'(tc), int'(m.tc));
  end

  // ---------------------------------------------------------------- driver tasks
  task automatic cyc(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_load(input int v);
    load = 1'b1; load_value = WIDTH'(v);
    cyc();
    load = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  // Edges until tc is seen, bounded; -1 when the bound expires.
  task automatic edges_to_tc(input int max_edges, output int n);
    n = -1;
    for (int i = 1; i <= max_edges; i++) begin
      cyc();
      if (tc) begin
        n = i;
        break;
      end
    end
  endtask

  // ---------------------------------------------------------------- directed + random
  initial begin
    int n;
    int tc_seen;
    int last_tc;

    // Reset then idle
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    check("rst_q", int'(q), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_tc", int'(tc), 0);
    tc_seen = 0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (q != 0 || busy || done || tc) tc_seen = 1;
    end
    check("idle_no_change", tc_seen, 0);

    // One-shot: 5,4,3,2,1,0 on consecutive clocks
    prescale = 0; auto_reload = 1'b0;
    do_load(5);
    do_start();
    check("os_q_start", int'(q), 5);
    check("os_busy", int'(busy), 1);
    for (int i = 0; i < 5; i++) begin
      cyc();
      check("os_q_step", int'(q), 4 - i);
      check("os_tc_step", int'(tc), int'(i == 4));
    end
    cyc();
    check("os_done", int'(done), 1);
    check("os_busy_off", int'(busy), 0);
    check("os_q_hold", int'(q), 0);
    check("os_tc_once", int'(tc), 0);

    // Prescaled periodic: period 3*4 = 12 clocks
    prescale = 3; auto_reload = 1'b1;
    do_load(3);
    do_start();
    last_tc = 0;
    for (int k = 1; k <= 36; k++) begin
      cyc();
      check("per_q", int'(q), 3 - (k % 12) / 4);
      check("per_tc", int'(tc), int'(k % 12 == 0));
      check("per_busy", int'(busy), 1);
    end

    // Stop / resume: 7 counted clocks before stop, 11 after = 18
    prescale = 1; auto_reload = 1'b0;
    do_load(9);
    do_start();
    cyc(7);
    check("sr_q_before_stop", int'(q), 6);
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    check("sr_q_held", int'(q), 6);
    check("sr_busy_off", int'(busy), 0);
    cyc(3);
    check("sr_q_still", int'(q), 6);
    do_start();
    check("sr_busy_on", int'(busy), 1);
    edges_to_tc(40, n);
    check("sr_edges_to_tc", n, 11);

    // Priority / abort: load wins over stop and start
    prescale = 0; auto_reload = 1'b0;
    do_load(9);
    do_start();
    cyc(5);
    check("pr_q4", int'(q), 4);
    load = 1'b1; load_value = 4'd7; stop = 1'b1; start = 1'b1;
    cyc();
    load = 1'b0; stop = 1'b0; start = 1'b0;
    check("pr_q7", int'(q), 7);
    check("pr_busy", int'(busy), 0);
    check("pr_done", int'(done), 0);
    check("pr_tc", int'(tc), 0);
    do_start();
    edges_to_tc(20, n);
    check("pr_edges_to_tc", n, 7);
    cyc();
    check("pr_done_after", int'(done), 1);
    do_start();
    check("pr_restart_q", int'(q), 7);
    check("pr_restart_busy", int'(busy), 1);

    // Load 0 behaves like load 1 in auto-reload: period 1*(2+1) = 3
    prescale = 2; auto_reload = 1'b1;
    do_load(0);
    do_start();
    edges_to_tc(20, n);
    check("z_first_tc", n, 3);
    check("z_q_after_tc", int'(q), 0);
    edges_to_tc(20, n);
    check("z_second_tc", n, 3);

    // Async reset mid-run at q=2
    prescale = 0; auto_reload = 1'b0;
    do_load(5);
    do_start();
    cyc(3);
    check("ar_q2", int'(q), 2);
    #2 rst_n = 1'b0;
    #1;
    check("ar_q_clear", int'(q), 0);
    check("ar_busy_clear", int'(busy), 0);
    check("ar_tc_clear", int'(tc), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    tc_seen = 0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      if (tc || busy) tc_seen = 1;
    end
    check("ar_no_tc", tc_seen, 0);

    // Randomized traffic, checked every cycle against the model
    for (int i = 0; i < 2000; i++) begin
      load        = ($urandom_range(0, 24) == 0);
      load_value  = WIDTH'($urandom_range(0, 15));
      stop        = ($urandom_range(0, 29) == 0);
      start       = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 19) == 0) auto_reload = $urandom_range(0, 1) == 1;
      if ($urandom_range(0, 39) == 0) prescale = PRESCALE_W'($urandom_range(0, 4));
      cyc();
    end
    load = 1'b0; stop = 1'b0; start = 1'b0;
    cyc(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
